// File: rtl/rng_bounded_sampler.sv
// Mask-and-reject sampler: turns a raw 32-bit random word stream into uniform
// integers in [0, N) and delivers them through a small output FIFO.
module rng_bounded_sampler #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [31:0]          cfg_bound,
    output logic                 cfg_err,
    input  logic                 in_valid,
    input  logic [31:0]          in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [31:0]          out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] reject_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_W  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t               state_q;
    logic [31:0]          bound_q;
    logic [31:0]          mask_q;
    logic [31:0]          s1_data_q;
    logic                 s1_valid_q;
    logic                 cfg_err_q;
    logic [CNT_WIDTH-1:0] reject_q;
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [31:0]          out_data_q;
    logic [31:0]          fifo_mem [FIFO_DEPTH];

    logic [31:0]          out_data_d;
    logic [31:0]          cand;
    logic                 cand_ok;
    logic                 fifo_room;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [PW-1:0]        rd_next;

    // Smear bound-1 downwards so every bit at or below its MSB is set.
    logic [31:0] smear [6];
    assign smear[0] = bound_q - 32'd1;
    for (genvar gi = 0; gi < 5; gi++) begin : g_smear
        assign smear[gi+1] = smear[gi] | (smear[gi] >> (1 << gi));
    end

    // Stage 1 counts against capacity so a word in flight always has a slot.
    assign fifo_room = ({1'b0, count_q} + {{CW{1'b0}}, s1_valid_q}) < DEPTH_W;
    assign in_ready  = (state_q == RUN) && fifo_room;
    assign out_valid = (count_q != '0);
    assign accept    = in_ready && in_valid && !cfg_valid;
    assign cand      = in_data & mask_q;
    assign cand_ok   = cand < bound_q;
    assign push      = s1_valid_q;
    assign pop       = out_valid && out_ready;
    assign rd_next   = rd_ptr_q + 1'b1;

    // out_data is a register tracking the FIFO head, so it holds while stalled.
    always_comb begin
        out_data_d = out_data_q;
        if (pop) begin
            if (count_q > CW'(1)) begin
                out_data_d = fifo_mem[rd_next];
            end else if (push) begin
                out_data_d = s1_data_q;
            end
        end else if (!out_valid && push) begin
            out_data_d = s1_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push && state_q == RUN) begin
            fifo_mem[wr_ptr_q] <= s1_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bound_q    <= '0;
            mask_q     <= '0;
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            reject_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
        end else begin
            out_data_q <= out_data_d;
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_bound != '0) begin
                            bound_q <= cfg_bound;
                            state_q <= LOAD;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    mask_q   <= smear[5];
                    reject_q <= '0;
                    state_q  <= RUN;
                end
                RUN: begin
                    if (cfg_valid) begin
                        // Any reconfiguration drops queued and in-flight samples.
                        s1_valid_q <= 1'b0;
                        count_q    <= '0;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        if (cfg_bound != '0) begin
                            bound_q <= cfg_bound;
                            state_q <= LOAD;
                        end else begin
                            cfg_err_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end else begin
                        s1_valid_q <= accept && cand_ok;
                        if (accept) begin
                            s1_data_q <= cand;
                        end
                        if (accept && !cand_ok && reject_q != '1) begin
                            reject_q <= reject_q + 1'b1;
                        end
                        if (push) begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                        if (pop) begin
                            rd_ptr_q <= rd_next;
                        end
                        count_q <= count_q + CW'(push) - CW'(pop);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(pop && count_q == '0));
            assert (!(push && count_q == FULL_W));
        end
    end

    assign cfg_err      = cfg_err_q;
    assign out_data     = out_data_q;
    assign busy         = (state_q != IDLE);
    assign reject_count = reject_q;

endmodule

// File: tb/tb_rng_bounded_sampler.sv
// Bench for rng_bounded_sampler: directed scenarios plus randomized traffic,
// all checked against a queue-based model of the sampling rules.
module tb_rng_bounded_sampler;

    localparam int          DEPTH = 4;
    localparam int unsigned SAT   = 32'h0000FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [31:0] cfg_bound;
    logic        cfg_err;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic [15:0] reject_count;

    rng_bounded_sampler #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_bound    (cfg_bound),
        .cfg_err      (cfg_err),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .busy         (busy),
        .reject_count (reject_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: samples accepted but not yet delivered, oldest first.
    logic [31:0] exp_q  [$];
    logic [31:0] want_q [$];
    logic [31:0] got_q  [$];
    bit          m_run, m_load, m_err, s1_pending;
    logic [31:0] m_bound, m_mask;
    int unsigned m_rej;
    int          proto_bad = 0;
    string       bad_info = "";

    function automatic logic [31:0] ref_mask(input logic [31:0] b);
        logic [31:0] t;
        logic [63:0] m;
        int          h;
        t = b - 32'd1;
        h = -1;
        for (int i = 0; i < 32; i++) if (t[i]) h = i;
        m = (64'd1 << (h + 1)) - 64'd1;
        return m[31:0];
    endfunction

    function automatic bit seq_equal();
        if (got_q.size() != want_q.size()) return 1'b0;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== want_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        exp_q.delete(); want_q.delete(); got_q.delete();
        m_run = 0; m_load = 0; m_err = 0; s1_pending = 0;
        m_bound = '0; m_mask = '0; m_rej = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_bound = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One clock of stimulus; the model advances alongside the DUT.
    task automatic drive_cycle(input logic cv, input logic [31:0] cb, input logic iv,
                               input logic [31:0] id, input logic ordy);
        bit          exp_ir, exp_ov, acc;
        logic [31:0] c;
        cfg_valid = cv; cfg_bound = cb; in_valid = iv; in_data = id; out_ready = ordy;
        exp_ir = m_run && (exp_q.size() < DEPTH);
        exp_ov = (exp_q.size() - int'(s1_pending)) > 0;
        if (in_ready !== exp_ir || out_valid !== exp_ov) begin
            proto_bad++;
            if (bad_info == "")
                bad_info = $sformatf("t=%0t in_ready=%b want %b out_valid=%b want %b",
                                     $time, in_ready, exp_ir, out_valid, exp_ov);
        end
        if (out_valid === 1'b1 && ordy) begin
            got_q.push_back(out_data);
            $display("sample %08h at t=%0t", out_data, $time);
        end
        if (exp_ov && ordy) want_q.push_back(exp_q.pop_front());
        acc = exp_ir && iv && !cv;
        s1_pending = 0;
        if (m_load) begin
            m_load = 0; m_run = 1; m_mask = ref_mask(m_bound); m_rej = 0;
        end else if (cv) begin
            exp_q.delete();
            m_run = 0;
            if (cb == 32'd0) m_err = 1;
            else begin m_bound = cb; m_load = 1; end
        end else if (acc) begin
            c = id & m_mask;
            if (c < m_bound) begin exp_q.push_back(c); s1_pending = 1; end
            else if (m_rej < SAT) m_rej++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
        checks++; if (reject_count !== 16'd0) begin errors++; $display("FAIL reset_reject: got %0d want 0", reject_count); end
    endtask

    task automatic test_bound10();
        int pb0 = proto_bad;
        drive_cycle(1, 32'd10, 0, 0, 1);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b10_load: busy=%b in_ready=%b want 1/0", busy, in_ready); end
        drive_cycle(0, 0, 0, 0, 1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b10_run_ready: got %b want 1", in_ready); end
        drive_cycle(0, 0, 1, 32'h00000003, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b10_lat1: out_valid=%b want 0", out_valid); end
        drive_cycle(0, 0, 1, 32'h0000000C, 1);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'd3) begin errors++; $display("FAIL b10_lat2: out_valid=%b data=%h want 1/3", out_valid, out_data); end
        drive_cycle(0, 0, 1, 32'h12345679, 1);
        repeat (4) drive_cycle(0, 0, 0, 0, 1);
        checks++; if (got_q.size() != 2 || got_q[0] !== 32'd3 || got_q[1] !== 32'd9) begin errors++; $display("FAIL b10_seq: got %0d samples want 3,9", got_q.size()); end
        checks++; if (reject_count !== 16'd1) begin errors++; $display("FAIL b10_reject: got %0d want 1", reject_count); end
        checks++; if (proto_bad != pb0) begin errors++; $display("FAIL b10_handshake: %s", bad_info); end
    endtask

    task automatic test_bound1();
        int pb0 = proto_bad;
        bit zeros = 1;
        drive_cycle(1, 32'd1, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 1);
        got_q.delete(); want_q.delete();
        for (int i = 0; i < 8; i++) drive_cycle(0, 0, 1, $urandom, 1);
        repeat (4) drive_cycle(0, 0, 0, 0, 1);
        foreach (got_q[i]) if (got_q[i] !== 32'd0) zeros = 0;
        checks++; if (got_q.size() != 8 || !zeros) begin errors++; $display("FAIL b1_zeros: got %0d samples allzero=%b want 8/1", got_q.size(), zeros); end
        checks++; if (reject_count !== 16'd0) begin errors++; $display("FAIL b1_reject: got %0d want 0", reject_count); end
        drive_cycle(1, 32'd0, 0, 0, 1);
        checks++; if (cfg_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL b0_err: cfg_err=%b busy=%b in_ready=%b want 1/0/0", cfg_err, busy, in_ready); end
        checks++; if (proto_bad != pb0) begin errors++; $display("FAIL b1_handshake: %s", bad_info); end
    endtask

    task automatic test_backpressure();
        int pb0 = proto_bad;
        int n0;
        bit ok = 1;
        logic [31:0] w [10];
        drive_cycle(1, 32'd16, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0);
        got_q.delete(); want_q.delete();
        for (int i = 0; i < 10; i++) begin w[i] = $urandom; drive_cycle(0, 0, 1, w[i], 0); end
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_full: in_ready=%b out_valid=%b want 0/1", in_ready, out_valid); end
        repeat (4) drive_cycle(0, 0, 1, $urandom, 1);
        if (got_q.size() != 4) ok = 0;
        else for (int i = 0; i < 4; i++) if (got_q[i] !== (w[i] & 32'hF)) ok = 0;
        checks++; if (!ok) begin errors++; $display("FAIL bp_order: got %0d samples in order=%b want 4 matching inputs", got_q.size(), ok); end
        n0 = got_q.size();
        repeat (8) drive_cycle(0, 0, 1, $urandom, 1);
        checks++; if (got_q.size() - n0 != 8) begin errors++; $display("FAIL bp_stream: got %0d samples in 8 cycles want 8", got_q.size() - n0); end
        repeat (8) drive_cycle(0, 0, 0, 0, 1);
        checks++; if (!seq_equal()) begin errors++; $display("FAIL bp_seq: got %0d samples want %0d", got_q.size(), want_q.size()); end
        checks++; if (proto_bad != pb0) begin errors++; $display("FAIL bp_handshake: %s", bad_info); end
    endtask

    task automatic test_reconfig();
        int pb0 = proto_bad;
        bit inrange = 1;
        drive_cycle(1, 32'd12, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(0, 0, 1, 32'h0000000F, 0);
        drive_cycle(0, 0, 1, 32'h00000001, 0);
        drive_cycle(0, 0, 1, 32'h00000002, 0);
        drive_cycle(0, 0, 1, 32'h00000003, 0);
        drive_cycle(0, 0, 0, 0, 0);
        checks++; if (reject_count !== 16'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL rc_pre: reject=%0d out_valid=%b want 1/1", reject_count, out_valid); end
        drive_cycle(1, 32'd100, 1, $urandom, 0);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rc_flush: out_valid=%b busy=%b in_ready=%b want 0/1/0", out_valid, busy, in_ready); end
        drive_cycle(0, 0, 0, 0, 0);
        checks++; if (reject_count !== 16'd0) begin errors++; $display("FAIL rc_rej_clear: got %0d want 0", reject_count); end
        got_q.delete(); want_q.delete();
        drive_cycle(0, 0, 1, 32'h000000FF, 1);
        drive_cycle(0, 0, 1, 32'h00000063, 1);
        for (int i = 0; i < 30; i++) drive_cycle(0, 0, ($urandom % 4) != 0, $urandom, ($urandom % 3) != 0);
        repeat (8) drive_cycle(0, 0, 0, 0, 1);
        foreach (got_q[i]) if (got_q[i] >= 32'd100) inrange = 0;
        checks++; if (got_q.size() == 0 || got_q[0] !== 32'd99) begin errors++; $display("FAIL rc_first: got %0d samples, want first 99", got_q.size()); end
        checks++; if (!inrange) begin errors++; $display("FAIL rc_range: a sample >= 100 was delivered, want all < 100"); end
        checks++; if (reject_count !== 16'(m_rej)) begin errors++; $display("FAIL rc_reject: got %0d want %0d", reject_count, m_rej); end
        checks++; if (!seq_equal()) begin errors++; $display("FAIL rc_seq: got %0d samples want %0d", got_q.size(), want_q.size()); end
        checks++; if (proto_bad != pb0) begin errors++; $display("FAIL rc_handshake: %s", bad_info); end
    endtask

    task automatic test_reset_mid();
        int pb0;
        drive_cycle(0, 0, 1, 32'd5, 0);
        drive_cycle(0, 0, 1, 32'd6, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre: out_valid=%b want 1", out_valid); end
        rst = 1'b1; in_valid = 1'b1; in_data = 32'd7; out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL rm_data: out_valid=%b out_data=%h in_ready=%b want 0/0/0", out_valid, out_data, in_ready); end
        checks++; if (busy !== 1'b0 || cfg_err !== 1'b0 || reject_count !== 16'd0) begin errors++; $display("FAIL rm_status: busy=%b cfg_err=%b reject=%0d want 0/0/0", busy, cfg_err, reject_count); end
        rst = 1'b0;
        model_clear();
        pb0 = proto_bad;
        repeat (4) drive_cycle(0, 0, 1, $urandom, 1);
        checks++; if (got_q.size() != 0 || proto_bad != pb0) begin errors++; $display("FAIL rm_after: %0d samples after reset want 0 (%s)", got_q.size(), bad_info); end
    endtask

    task automatic test_max_bound();
        drive_cycle(1, 32'hFFFFFFFF, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 1);
        got_q.delete(); want_q.delete();
        drive_cycle(0, 0, 1, 32'hFFFFFFFF, 1);
        drive_cycle(0, 0, 1, 32'hFFFFFFFE, 1);
        repeat (4) drive_cycle(0, 0, 0, 0, 1);
        checks++; if (reject_count !== 16'd1) begin errors++; $display("FAIL max_reject: got %0d want 1", reject_count); end
        checks++; if (got_q.size() != 1 || got_q[0] !== 32'hFFFFFFFE) begin errors++; $display("FAIL max_sample: got %0d samples want one fffffffe", got_q.size()); end
    endtask

    task automatic test_saturation();
        logic [31:0] r;
        drive_cycle(1, 32'd9, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 65534; i++) begin r = $urandom; drive_cycle(0, 0, 1, {r[31:4], 4'hF}, 1); end
        checks++; if (reject_count !== 16'hFFFE) begin errors++; $display("FAIL sat_near: got %h want fffe", reject_count); end
        for (int i = 0; i < 6; i++) begin r = $urandom; drive_cycle(0, 0, 1, {r[31:4], 4'hA}, 1); end
        checks++; if (reject_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", reject_count); end
        got_q.delete(); want_q.delete();
        drive_cycle(0, 0, 1, 32'h00000003, 1);
        repeat (4) drive_cycle(0, 0, 0, 0, 1);
        checks++; if (got_q.size() != 1 || got_q[0] !== 32'd3 || reject_count !== 16'hFFFF) begin errors++; $display("FAIL sat_accept: got %0d samples reject=%h want one 3 and ffff", got_q.size(), reject_count); end
    endtask

    task automatic test_random();
        logic [31:0] b;
        for (int r = 0; r < 6; r++) begin
            int pb0 = proto_bad;
            case (r)
                0: b = 32'd64;
                1: b = $urandom_range(1, 40);
                2: begin b = $urandom; if (b == 32'd0) b = 32'd1; end
                3: b = 32'h80000001;
                4: b = 32'd1000;
                default: b = $urandom_range(2, 7);
            endcase
            drive_cycle(1, b, 0, 0, 1);
            drive_cycle(0, 0, 0, 0, 1);
            got_q.delete(); want_q.delete();
            for (int i = 0; i < 200; i++) drive_cycle(0, 0, ($urandom % 4) != 0, $urandom, ($urandom % 4) != 0);
            repeat (8) drive_cycle(0, 0, 0, 0, 1);
            checks++; if (!seq_equal()) begin errors++; $display("FAIL rnd_seq bound=%0d: got %0d samples want %0d", b, got_q.size(), want_q.size()); end
            checks++; if (reject_count !== 16'(m_rej)) begin errors++; $display("FAIL rnd_reject bound=%0d: got %0d want %0d", b, reject_count, m_rej); end
            checks++; if (proto_bad != pb0) begin errors++; $display("FAIL rnd_handshake bound=%0d: %s", b, bad_info); end
            if (r == 0) begin
                checks++; if (reject_count !== 16'd0) begin errors++; $display("FAIL rnd_pow2: reject=%0d want 0", reject_count); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_bound = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_clear();
        test_reset();
        test_bound10();
        test_bound1();
        test_backpressure();
        test_reconfig();
        test_reset_mid();
        test_max_bound();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
